// File: rtl/bin2sseg_4dig.sv
// rtl/bin2sseg_4dig.sv - binary to four active-low seven-segment digit patterns
// Sequential double-dabble (one bit per clock) followed by one encode cycle.

module bin2sseg_4dig #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic             blank_lz,
    input  logic [3:0]       dp_sel,
    output logic             ready,
    output logic             done,
    output logic             overflow,
    output logic [7:0]       dig3,
    output logic [7:0]       dig2,
    output logic [7:0]       dig1,
    output logic [7:0]       dig0
);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [3:0] LAST_CNT  = 4'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_t;

    state_t           r_state;
    logic [BIN_W-1:0] r_bin;
    logic [15:0]      r_bcd;
    logic [3:0]       r_cnt;
    logic             r_lz;
    logic [3:0]       r_dp;
    logic             r_ovf_acc;
    logic             r_ready;
    logic             r_done;
    logic             r_overflow;
    logic [7:0]       r_dig [4];

    logic [15:0]      w_bcd_adj;
    logic [3:0]       w_blank;
    logic [7:0]       w_pat [4];

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Blanking cascades downward from dig3; dig0 always shows its value.
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = r_lz && (r_bcd[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_bcd[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_bcd[7:4] == 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (r_ovf_acc)
                w_pat[i] = SEG_DASH;
            else if (w_blank[i])
                w_pat[i] = SEG_BLANK;
            else
                w_pat[i] = seg7(r_bcd[4*i +: 4]);
            if (r_dp[i])
                w_pat[i][7] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_lz       <= 1'b0;
            r_dp       <= '0;
            r_ovf_acc  <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < 4; i++)
                r_dig[i] <= SEG_BLANK;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin     <= bin;
                        r_lz      <= blank_lz;
                        r_dp      <= dp_sel;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_ready   <= 1'b0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Any bit leaving the top nibble is a ten-thousands carry, i.e. value > 9999.
                    r_ovf_acc <= r_ovf_acc | w_bcd_adj[15];
                    r_bcd     <= {w_bcd_adj[14:0], r_bin[BIN_W-1]};
                    r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + 4'd1;
                    if (r_cnt == LAST_CNT)
                        r_state <= ENCODE;
                end
                ENCODE: begin
                    for (int i = 0; i < 4; i++)
                        r_dig[i] <= w_pat[i];
                    r_overflow <= r_ovf_acc;
                    r_done     <= 1'b1;
                    r_ready    <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign dig3     = r_dig[3];
    assign dig2     = r_dig[2];
    assign dig1     = r_dig[1];
    assign dig0     = r_dig[0];

endmodule

// File: doc/bin2sseg_4dig.md
Name: bin2sseg_4dig

Overview:
Converts an unsigned binary value into four active-low seven-segment digit patterns for the 4-digit multiplexed display driver (mux_sseg_4dig). The driver consumes these patterns on its dig3..dig0 inputs.
- Conversion is sequential: double-dabble shift/add-3, one bit per clock, then one encode cycle.
- Options: leading-zero blanking, per-digit decimal point, overflow indication.
- Outputs are registered and held stable between conversions, so the display driver always sees a coherent 4-digit set.

Parameters:
- BIN_W, 14, width of binary input. Legal range 4..14. Conversion takes BIN_W shift cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request conversion; accepted only when ready=1.
- bin  in  BIN_W  unsigned value; sampled on the accepting edge.
- blank_lz  in  1  1 = blank leading zeros on dig3..dig1; sampled with bin.
- dp_sel  in  4  per-digit decimal point enable, bit i -> dig i, active-high; sampled with bin.
- ready  out  1  1 = idle, start will be accepted.
- done  out  1  one-cycle pulse when new digits are written.
- overflow  out  1  1 = last accepted value > 9999; held until the next completed conversion.
- dig3  out  8  most-significant digit pattern.
- dig2  out  8  digit 2 pattern.
- dig1  out  8  digit 1 pattern.
- dig0  out  8  least-significant digit pattern.

Behaviour:
- Pattern format: {dp,g,f,e,d,c,b,a}, active-low.
  - Digits 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90.
  - Blank = FF. Dash = BF.
  - dp enabled: clear bit 7. This is applied after blanking, so a blanked digit with dp enabled gives 7F.
- Reset (reset=0, asynchronous):
  - ready=1, done=0, overflow=0, dig3..dig0=FF.
  - FSM goes to IDLE; shift register and counter are cleared.
  - Any conversion in progress is aborted and no done pulse is produced.
- FSM states: IDLE, SHIFT, ENCODE.
- IDLE, on an edge with start=1:
  - Capture bin, blank_lz and dp_sel; clear the 16-bit BCD register; counter=0.
  - ready->0; next state SHIFT.
- SHIFT, each edge:
  - Every BCD nibble >=5 gets +3.
  - Then shift {bcd,bin} left by 1.
  - counter+1; after the BIN_W-th shift, next state ENCODE.
- ENCODE, one edge:
  - Write dig3..dig0 and overflow; done=1 for this cycle only; ready->1; next state IDLE.
- Latency: if start is accepted at edge E, new digits, done=1 and ready=1 are visible after edge E+BIN_W+1 (E+15 at default). Latency is identical for every value, including overflow.
- Back-to-back: start=1 in the same cycle that done=1 is accepted, so the next conversion starts immediately.
- Overflow (captured bin > 9999, only possible when BIN_W=14):
  - All four digits = BF, overflow=1.
  - dp_sel still applies; blanking is ignored.
- Leading-zero blanking (blank_lz=1):
  - Blank dig3, then dig2, then dig1, while each is zero and all more-significant digits are blanked.
  - dig0 is never blanked.
- start while ready=0: ignored, with no side effects. bin changes during a conversion have no effect.
- Outputs change only on the ENCODE edge or on reset.

Test Plan:
- Reset, then release: dig*=FF, ready=1, done=0, overflow=0. Assert reset at cycle 7 of a conversion: outputs return to FF/ready=1 immediately, no done pulse follows.
- bin=1234, blank_lz=0, dp_sel=0000: done exactly 15 cycles after the accept edge; dig3..0=F9,A4,B0,99; overflow=0.
- bin=7, blank_lz=1: FF,FF,FF,F8. bin=7, blank_lz=0: C0,C0,C0,F8. bin=0, blank_lz=1: FF,FF,FF,C0.
- bin=9999: 90,90,90,90, overflow=0. bin=10000: BF,BF,BF,BF, overflow=1. Next conversion of bin=5 clears overflow.
- bin=1234, dp_sel=0100: dig2=24, other digits unchanged. bin=5, blank_lz=1, dp_sel=1000: dig3=7F.
- start=1 on every cycle with bin alternating 1111/2222: exactly one conversion per 16 cycles, starts only on ready=1 edges, bin changes mid-conversion ignored, done pulses are one cycle wide.
